// File: rtl/rc_trap_integrator.sv
// rc_trap_integrator: multi-channel fixed-point trapezoidal capacitor model.
// Integrates CH current channels into voltages, V += k*(I + Iprev), using one
// shared multiply-add that walks the channels one per cycle.
// Optional feature macro: RC_LEAK_EN adds a parallel-resistor leak term
// V >>> LEAK_SHIFT, subtracted on every update.
`timescale 1ns/1ps
module rc_trap_integrator #(
    parameter int CH = 4,
    parameter int IW = 16,
    parameter int VW = 24,
`ifdef RC_LEAK_EN
    parameter int KW = 16,
    parameter int LEAK_SHIFT = 8
`else
    parameter int KW = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH*IW-1:0] i_in,
    input  logic [KW-1:0]    k,
    output logic             out_valid,
    output logic [CH*VW-1:0] v_out,
    output logic [CH-1:0]    sat
);

    // Product width, and an accumulator width that cannot overflow before clamping
    localparam int PW  = IW + KW + 2;
    localparam int AW  = ((VW > PW) ? VW : PW) + 2;
    localparam int CIW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [VW-1:0] VMAX   = {1'b0, {(VW-1){1'b1}}};
    localparam logic signed [VW-1:0] VMIN   = {1'b1, {(VW-1){1'b0}}};
    localparam logic signed [AW-1:0] VMAX_X = AW'(VMAX);
    localparam logic signed [AW-1:0] VMIN_X = AW'(VMIN);
    localparam logic [CIW-1:0]       LAST   = CIW'(CH - 1);

    logic [1:0]               state_q, state_d;
    logic [CIW-1:0]           ch_idx_q, ch_idx_d;
    logic [CH-1:0][IW-1:0]    i_lat_q, i_lat_d;
    logic [CH-1:0][IW-1:0]    i_prev_q, i_prev_d;
    logic [CH-1:0][VW-1:0]    v_q, v_d;
    logic [KW-1:0]            k_q, k_d;
    logic [CH-1:0]            sat_q, sat_d;

    logic [IW-1:0]            cur_i, cur_p;
    logic [VW-1:0]            cur_v;
    logic signed [IW:0]       sum;
    logic signed [PW-1:0]     sum_x, k_x, prod, delta;
    logic signed [AW-1:0]     acc, v_x, d_x;
    logic signed [VW-1:0]     v_new;
    logic                     ovf;

    // Shared datapath: trapezoid increment for the channel at ch_idx, then clamp
    always_comb begin
        cur_i = i_lat_q[ch_idx_q];
        cur_p = i_prev_q[ch_idx_q];
        cur_v = v_q[ch_idx_q];
        sum   = $signed({cur_i[IW-1], cur_i}) + $signed({cur_p[IW-1], cur_p});
        sum_x = sum;
        k_x   = $signed({{(PW-KW){1'b0}}, k_q});
        prod  = sum_x * k_x;
        // Arithmetic shift floors toward minus infinity
        delta = prod >>> KW;
        v_x   = $signed(cur_v);
        d_x   = delta;
`ifdef RC_LEAK_EN
        acc   = v_x + d_x - (v_x >>> LEAK_SHIFT);
`else
        acc   = v_x + d_x;
`endif
        ovf   = 1'b1;
        if (acc > VMAX_X) begin
            v_new = VMAX;
        end else if (acc < VMIN_X) begin
            v_new = VMIN;
        end else begin
            v_new = acc[VW-1:0];
            ovf   = 1'b0;
        end
    end

    // Next-state: accept in IDLE, one channel per CALC cycle, one DONE pulse
    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        i_lat_d  = i_lat_q;
        i_prev_d = i_prev_q;
        v_d      = v_q;
        k_d      = k_q;
        sat_d    = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    i_lat_d  = i_in;
                    k_d      = k;
                    ch_idx_d = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                v_d[ch_idx_q]      = v_new;
                i_prev_d[ch_idx_q] = i_lat_q[ch_idx_q];
                if (ovf) sat_d[ch_idx_q] = 1'b1;
                if (ch_idx_q == LAST) state_d = ST_DONE;
                else                  ch_idx_d = ch_idx_q + CIW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset clears everything and aborts any set in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_idx_q <= '0;
            i_lat_q  <= '0;
            i_prev_q <= '0;
            v_q      <= '0;
            k_q      <= '0;
            sat_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            i_lat_q  <= i_lat_d;
            i_prev_q <= i_prev_d;
            v_q      <= v_d;
            k_q      <= k_d;
            sat_q    <= sat_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign v_out     = v_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_rc_trap_integrator.sv
// Directed bench for rc_trap_integrator (CH=4, IW=16, VW=24, KW=16).
`timescale 1ns/1ps
module tb_rc_trap_integrator;
    localparam int CH = 4;
    localparam int IW = 16;
    localparam int VW = 24;
    localparam int KW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CH*IW-1:0] i_in;
    logic [KW-1:0]    k;
    logic             out_valid;
    logic [CH*VW-1:0] v_out;
    logic [CH-1:0]    sat;

    int total = 0;
    int bad   = 0;

    rc_trap_integrator #(.CH(CH), .IW(IW), .VW(VW), .KW(KW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i_in(i_in), .k(k), .out_valid(out_valid), .v_out(v_out), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] vch(input int c);
        logic signed [VW-1:0] t;
        t = v_out[c*VW +: VW];
        return 64'(t);
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one sample set, wait for accept, and check exactly one out_valid
    // arriving CH cycles after the accept edge. Returns #1 after the edge
    // on which the FSM is back in IDLE.
    task automatic apply(input logic [IW-1:0] a0, a1, a2, a3, input logic [KW-1:0] kk);
        int w = 0;
        int pulses = 0;
        int late = 0;
        i_in = {a3, a2, a1, a0};
        k = kk;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) chk("ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= CH + 1; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                pulses++;
                if (n != CH) late++;
            end
        end
        chk("one_pulse", pulses, 1);
        if (late != 0) chk("pulse_latency", late, 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; in_valid = 1'b0; i_in = '0; k = '0;

        // Reset state, checked while still in reset and after release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_vout", (v_out == '0), 1);
        chk("rst_sat", sat, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_vout", (v_out == '0), 1);

        // Ramp on channel 0
        apply(16'd100, 16'd0, 16'd0, 16'd0, 16'd32768);
        chk("ramp_v0_1", vch(0), 50);
        apply(16'd100, 16'd0, 16'd0, 16'd0, 16'd32768);
        chk("ramp_v0_2", vch(0), 150);
        apply(16'd100, 16'd0, 16'd0, 16'd0, 16'd32768);
        chk("ramp_v0_3", vch(0), 250);
        chk("ramp_v1", vch(1), 0);
        chk("ramp_v2", vch(2), 0);
        chk("ramp_v3", vch(3), 0);

        // Negative input on channel 1; channel 0 gets its trailing half-step
        apply(16'd0, -16'sd100, 16'd0, 16'd0, 16'd32768);
        chk("neg_v1_1", vch(1), -50);
        chk("neg_v0", vch(0), 300);
        apply(16'd0, -16'sd100, 16'd0, 16'd0, 16'd32768);
        chk("neg_v1_2", vch(1), -150);
        chk("neg_v0_hold", vch(0), 300);

        // Floor rounding: -1 * 0.5 -> -1
        do_reset();
        apply(16'd0, 16'd0, -16'sd1, 16'd0, 16'd32768);
        chk("floor_v2", vch(2), -1);
        chk("floor_v0", vch(0), 0);

        // k = 0 holds V while Iprev still tracks the input
        apply(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("k0_hold_v2", vch(2), -1);
        apply(16'd0, 16'd0, 16'd0, 16'd0, 16'd32768);
        chk("k0_prev_cleared", vch(2), -1);

        // Saturation: 32766 first, then +65533 per set; clamps on set 129
        do_reset();
        for (int s = 1; s <= 128; s++) apply(16'd0, 16'd0, 16'd0, 16'd32767, 16'd65535);
        chk("sat_pre_v3", vch(3), 8355457);
        chk("sat_pre_flag", sat, 0);
        apply(16'd0, 16'd0, 16'd0, 16'd32767, 16'd65535);
        chk("sat_clamp_v3", vch(3), 8388607);
        chk("sat_flag", sat, 4'b1000);
        apply(16'd0, 16'd0, 16'd0, 16'd32767, 16'd65535);
        chk("sat_stay_v3", vch(3), 8388607);
        chk("sat_stay_flag", sat, 4'b1000);
        chk("sat_v0", vch(0), 0);

        // Handshake with in_valid held high: accepts every 6 cycles
        do_reset();
        i_in = '0; k = 16'd32768; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 14; n++) begin
            chk($sformatf("hs_ready_E%0d", n), in_ready, ((n % 6) == 5) ? 1 : 0);
            chk($sformatf("hs_ovalid_E%0d", n), out_valid, ((n % 6) == 4) ? 1 : 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // Reset during CALC aborts the set
        do_reset();
        i_in = {16'd0, 16'd0, 16'd0, 16'd100}; k = 16'd32768; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_v0", vch(0), 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_sat", sat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
